// File: rtl/gate_edge_counter.sv
// ============================================================================
// gate_edge_counter
//
// Purpose:
//   Counts rising edges of an asynchronous input signal inside a measurement
//   window defined by a clk-synchronous gate. The result of each completed
//   window is published on count together with a one-cycle count_valid pulse.
//   The internal accumulator saturates instead of wrapping, and overflow
//   records that the window saturated.
//
// Parameters:
//   WIDTH        - width of the accumulator and of the count output
//
// Ports:
//   clk          - system clock, all flops on its rising edge
//   rst_n        - asynchronous active-low reset
//   sigin        - measured signal, asynchronous to clk
//   gate         - measurement window, synchronous to clk, high = count
//   count        - rising edges seen in the last completed window
//   count_valid  - one-cycle pulse when count/overflow update
//   overflow     - last completed window saturated the accumulator
//   busy         - high while a window is being counted
//
// Configuration:
//   GATE_EDGE_COUNTER_GLITCH_FILTER_EN - when defined, a 3-sample majority
//   (all-agree) filter sits between the synchronizer and the edge detector,
//   rejecting pulses shorter than 3 clk periods at the cost of 3 clk of extra
//   edge latency. When undefined no filter logic exists.
// ============================================================================
module gate_edge_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sigin,
    input  logic             gate,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ACC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             sigLevel;
    logic             sigPrev_q;
    logic             sigEdge;
    logic             gatePrev_q;
    logic             gateRise;
    logic             gateFall;
    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             flag_q,   flag_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             valid_q,  valid_d;

    // Two-flop synchronizer bringing sigin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
        end else begin
            syncMeta_q <= sigin;
            syncOut_q  <= syncMeta_q;
        end
    end

`ifdef GATE_EDGE_COUNTER_GLITCH_FILTER_EN
    logic [2:0] filtSh_q;
    logic       filtLvl_q;
    logic       filtLvl_d;

    // The filtered level only moves when all three history samples agree,
    // otherwise it holds. The next-state value feeds the edge detector
    // directly so the filter adds exactly three cycles of latency.
    always_comb begin
        filtLvl_d = filtLvl_q;
        if (&filtSh_q) begin
            filtLvl_d = 1'b1;
        end else if (~|filtSh_q) begin
            filtLvl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filtSh_q  <= 3'b000;
            filtLvl_q <= 1'b0;
        end else begin
            filtSh_q  <= {filtSh_q[1:0], syncOut_q};
            filtLvl_q <= filtLvl_d;
        end
    end

    assign sigLevel = filtLvl_d;
`else
    assign sigLevel = syncOut_q;
`endif

    // Delayed copies of the signal level and gate for edge/strobe detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sigPrev_q  <= 1'b0;
            gatePrev_q <= 1'b0;
        end else begin
            sigPrev_q  <= sigLevel;
            gatePrev_q <= gate;
        end
    end

    assign sigEdge  = sigLevel & ~sigPrev_q;
    assign gateRise = gate & ~gatePrev_q;
    assign gateFall = ~gate & gatePrev_q;

    // Window FSM. The result registers are loaded on the fall transition so
    // that they, and count_valid, are visible during the single DONE cycle.
    // Edges in the rise cycle are naturally excluded because the FSM is not
    // yet in COUNT; edges in the fall cycle are excluded by the gate term.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gateRise) begin
                    acc_d   = '0;
                    flag_d  = 1'b0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (gateFall) begin
                    count_d = acc_q;
                    ovf_d   = flag_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (sigEdge && gate) begin
                    if (acc_q == ACC_MAX) begin
                        flag_d = 1'b1;
                    end else begin
                        acc_d = acc_q + ACC_ONE;
                    end
                end
            end
            DONE: begin
                if (gateRise) begin
                    acc_d   = '0;
                    flag_d  = 1'b0;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count       = count_q;
    assign overflow    = ovf_q;
    assign count_valid = valid_q;
    assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_gate_edge_counter.sv
// ============================================================================
// tb_gate_edge_counter
//
// Directed bench for gate_edge_counter. Two instances share all inputs: the
// default WIDTH=32 one and a WIDTH=4 one used for saturation. Stimulus is
// indexed by "cycle" numbers: inputs for posedge N are driven on the negedge
// before it, and the outputs sampled on that same negedge reflect posedge
// N-1. The gate is high for posedges 1..L, so the fall strobe is at L+1 and
// count_valid is seen at sample L+2. A sigin pulse starting at cycle k is
// counted at posedge k+EDGE_LAT (2 without the filter, 5 with it).
// ============================================================================
module tb_gate_edge_counter;

`ifdef GATE_EDGE_COUNTER_GLITCH_FILTER_EN
    localparam int EDGE_LAT  = 5;
    localparam int GLITCH_EXP = 0;
`else
    localparam int EDGE_LAT  = 2;
    localparam int GLITCH_EXP = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sigin = 1'b0;
    logic        gate = 1'b0;
    logic [31:0] count;
    logic        count_valid;
    logic        overflow;
    logic        busy;
    logic [3:0]  count4;
    logic        countValid4;
    logic        overflow4;
    logic        busy4;

    int checks = 0;
    int failures = 0;

    int          pulseQ[$];
    int          pulseW;
    int          gL1;
    int          gL2;
    int          busyFrom;
    int          busyTo;
    int          busyLow;
    int          vCyc[$];
    logic [31:0] vCount[$];
    logic        vOvf[$];
    logic [3:0]  vCount4[$];
    logic        vOvf4[$];
    logic        vCv4[$];

    gate_edge_counter dut (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .gate(gate),
        .count(count), .count_valid(count_valid),
        .overflow(overflow), .busy(busy)
    );

    gate_edge_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .gate(gate),
        .count(count4), .count_valid(countValid4),
        .overflow(overflow4), .busy(busy4)
    );

    always #10 clk = ~clk;

    function automatic logic gateOn(input int cyc);
        return (cyc >= 1 && cyc <= gL1) ||
               (gL2 > 0 && cyc >= gL1 + 2 && cyc <= gL1 + 1 + gL2);
    endfunction

    function automatic logic sigOn(input int cyc);
        foreach (pulseQ[i]) begin
            if (cyc >= pulseQ[i] && cyc < pulseQ[i] + pulseW) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clearRec();
        vCyc.delete(); vCount.delete(); vOvf.delete();
        vCount4.delete(); vOvf4.delete(); vCv4.delete();
        pulseQ.delete();
        busyLow = 0; busyFrom = 1; busyTo = -1;
        gL2 = 0; pulseW = 4;
    endtask

    task automatic runSeq(input int firstCyc, input int lastCyc);
        for (int cyc = firstCyc; cyc <= lastCyc; cyc++) begin
            @(negedge clk);
            if (count_valid) begin
                vCyc.push_back(cyc); vCount.push_back(count); vOvf.push_back(overflow);
                vCount4.push_back(count4); vOvf4.push_back(overflow4);
                vCv4.push_back(countValid4);
            end
            if (!busy && cyc >= busyFrom && cyc <= busyTo) busyLow++;
            gate  = gateOn(cyc);
            sigin = sigOn(cyc);
        end
        @(negedge clk);
        gate = 1'b0; sigin = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (count_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", count_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (busy4 !== 1'b0 || count4 !== 4'd0) begin failures++; $display("[TB] FAIL reset_w4: got busy=%b count=%0d expected 0/0", busy4, count4); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || count_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", busy, count_valid); end
    endtask

    task automatic test_basic_window();
        clearRec();
        gL1 = 1000; pulseW = 25;
        for (int n = 0; n <= 20; n++) pulseQ.push_back(5 + 50 * n);
        runSeq(-10, 1010);
        checks++; if (vCyc.size() != 1) begin failures++; $display("[TB] FAIL basic_pulses: got %0d expected 1", vCyc.size()); end
        if (vCyc.size() >= 1) begin
            checks++; if (vCyc[0] != 1002) begin failures++; $display("[TB] FAIL basic_latency: got cycle %0d expected 1002", vCyc[0]); end
            checks++; if (vCount[0] !== 32'd20) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 20", vCount[0]); end
            checks++; if (vOvf[0] !== 1'b0) begin failures++; $display("[TB] FAIL basic_ovf: got %b expected 0", vOvf[0]); end
        end
        checks++; if (count !== 32'd20) begin failures++; $display("[TB] FAIL basic_hold: got %0d expected 20", count); end
    endtask

    task automatic test_saturation();
        clearRec();
        gL1 = 170;
        for (int n = 0; n < 20; n++) pulseQ.push_back(3 + 8 * n);
        runSeq(-10, 180);
        checks++; if (vCyc.size() != 1) begin failures++; $display("[TB] FAIL sat_pulses: got %0d expected 1", vCyc.size()); end
        if (vCyc.size() >= 1) begin
            checks++; if (vCount4[0] !== 4'd15) begin failures++; $display("[TB] FAIL sat_count4: got %0d expected 15", vCount4[0]); end
            checks++; if (vOvf4[0] !== 1'b1) begin failures++; $display("[TB] FAIL sat_ovf4: got %b expected 1", vOvf4[0]); end
            checks++; if (vCv4[0] !== 1'b1) begin failures++; $display("[TB] FAIL sat_valid4: got %b expected 1", vCv4[0]); end
            checks++; if (vCount[0] !== 32'd20 || vOvf[0] !== 1'b0) begin failures++; $display("[TB] FAIL sat_wide: got %0d/%b expected 20/0", vCount[0], vOvf[0]); end
        end
        checks++; if (overflow4 !== 1'b1) begin failures++; $display("[TB] FAIL sat_ovf_hold: got %b expected 1", overflow4); end
    endtask

    task automatic test_single_cycle_gate();
        clearRec();
        gL1 = 1;
        runSeq(-10, 10);
        checks++; if (vCyc.size() != 1) begin failures++; $display("[TB] FAIL single_pulses: got %0d expected 1", vCyc.size()); end
        if (vCyc.size() >= 1) begin
            checks++; if (vCyc[0] != 3) begin failures++; $display("[TB] FAIL single_latency: got cycle %0d expected 3", vCyc[0]); end
            checks++; if (vCount[0] !== 32'd0) begin failures++; $display("[TB] FAIL single_count: got %0d expected 0", vCount[0]); end
        end
    endtask

    task automatic test_back_to_back();
        clearRec();
        gL1 = 30; gL2 = 30;
        pulseQ = '{5, 13, 21, 40};
        busyFrom = 2; busyTo = 62;
        runSeq(-10, 70);
        checks++; if (vCyc.size() != 2) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", vCyc.size()); end
        if (vCyc.size() >= 2) begin
            checks++; if (vCyc[0] != 32 || vCyc[1] != 63) begin failures++; $display("[TB] FAIL b2b_latency: got %0d,%0d expected 32,63", vCyc[0], vCyc[1]); end
            checks++; if (vCount[0] !== 32'd3) begin failures++; $display("[TB] FAIL b2b_count1: got %0d expected 3", vCount[0]); end
            checks++; if (vCount[1] !== 32'd1) begin failures++; $display("[TB] FAIL b2b_count2: got %0d expected 1", vCount[1]); end
        end
        checks++; if (busyLow != 1) begin failures++; $display("[TB] FAIL b2b_busy_low: got %0d cycles expected 1", busyLow); end
    endtask

    task automatic test_boundary_edges();
        clearRec();
        gL1 = 20;
        pulseQ = '{1 - EDGE_LAT, 20 - EDGE_LAT};
        runSeq(-10, 30);
        checks++; if (vCyc.size() != 1 || vCount[0] !== 32'd1) begin failures++; $display("[TB] FAIL boundary_rise: got %0d pulses count %0d expected 1/1", vCyc.size(), count); end
        clearRec();
        gL1 = 20;
        pulseQ = '{2 - EDGE_LAT, 21 - EDGE_LAT};
        runSeq(-10, 30);
        checks++; if (vCyc.size() != 1 || vCount[0] !== 32'd1) begin failures++; $display("[TB] FAIL boundary_fall: got %0d pulses count %0d expected 1/1", vCyc.size(), count); end
    endtask

    task automatic test_glitch_filter();
        clearRec();
        gL1 = 40; pulseW = 1;
        pulseQ = '{5, 10, 15, 20, 25};
        runSeq(-10, 50);
        checks++; if (vCyc.size() != 1 || vCount[0] != GLITCH_EXP) begin failures++; $display("[TB] FAIL glitch_short: got %0d pulses count %0d expected 1/%0d", vCyc.size(), count, GLITCH_EXP); end
        clearRec();
        gL1 = 40; pulseW = 4;
        pulseQ = '{5, 15, 25};
        runSeq(-10, 50);
        checks++; if (vCyc.size() != 1 || vCount[0] !== 32'd3) begin failures++; $display("[TB] FAIL glitch_long: got %0d pulses count %0d expected 1/3", vCyc.size(), count); end
    endtask

    task automatic test_reset_mid_window();
        int validSeen;
        validSeen = 0;
        @(negedge clk);
        gate = 1'b1;
        repeat (3) @(negedge clk);
        sigin = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (count !== 32'd0 || busy !== 1'b0 || count_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_clear: got count=%0d busy=%b valid=%b expected 0/0/0", count, busy, count_valid); end
        @(negedge clk);
        gate = 1'b0; sigin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (count_valid) validSeen++;
        end
        checks++; if (validSeen != 0 || count !== 32'd0) begin failures++; $display("[TB] FAIL mid_no_valid: got %0d pulses count %0d expected 0/0", validSeen, count); end
        gate = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_restart: got busy=%b expected 1", busy); end
        gate = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_saturation();
        test_single_cycle_gate();
        test_back_to_back();
        test_boundary_edges();
        test_glitch_filter();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
